// File: rtl/misp_perf_monitor_if.sv
// misp_perf_monitor_if: fetch-stream observation bus plus the statistics read port
interface misp_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      PC;
  logic [31:0]      Instr;
  logic             count_en;
  logic             clear;
  logic             snap;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             misalign_err;
  modport master (
    output PC, Instr, count_en, clear, snap, rd_sel,
    input  rd_data, misalign_err
  );
  modport slave (
    input  PC, Instr, count_en, clear, snap, rd_sel,
    output rd_data, misalign_err
  );
endinterface

// File: rtl/misp_perf_monitor.sv
// misp_perf_monitor: classifies fetch-stage events into saturating counters with an atomic
// shadow snapshot and a registered read port.
module misp_perf_monitor #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  misp_perf_monitor_if.slave bus
);
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  logic [7:0][CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic [CNT_W-1:0]      rd_q, rd_d;
  logic [31:0]           pc_q, pc_d;
  logic                  hist_v_q, hist_v_d, err_q, err_d;
  logic                  sampled, fetch, stall, redirect, misalign;
  logic [5:0]            op;
  logic [7:0]            ev;
  always_comb begin
    sampled  = bus.count_en && !bus.clear;
    op       = bus.Instr[31:26];
    fetch    = !hist_v_q || bus.PC != pc_q;
    stall    = !fetch;
    redirect = hist_v_q && bus.PC != pc_q && bus.PC != pc_q + 32'd4;
    misalign = bus.PC[1:0] != 2'b00;
    // bit order matches the rd_sel encoding
    ev = {misalign, fetch && (op == OP_BEQ || op == OP_BNE), fetch && op == OP_SW,
          fetch && op == OP_LW, redirect, stall, fetch, 1'b1};
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++)
      cnt_d[i] = bus.clear ? '0 : (sampled && ev[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
    shadow_d = bus.snap ? cnt_q : shadow_q;
    pc_d     = sampled ? bus.PC : pc_q;
    hist_v_d = bus.clear ? 1'b0 : sampled ? 1'b1 : hist_v_q;
    err_d    = err_q || (sampled && misalign);
    rd_d     = shadow_q[bus.rd_sel];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      hist_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      hist_v_q <= hist_v_d;
      err_q    <= err_d;
    end
  end
  assign bus.rd_data      = rd_q;
  assign bus.misalign_err = err_q;
endmodule

// File: doc/misp_perf_monitor.md
# misp_perf_monitor

Cycle-accurate performance and sanity monitor for the MISP five-stage pipeline. It sits directly downstream of the MISP core, observing the fetch-stage `PC` and `Instr` buses every cycle. It classifies fetch events (new fetch, stall, redirect, load, store, branch, misaligned PC) into saturating counters. An atomic snapshot and a registered read port let a testbench or debug host collect statistics without stopping the core.

## Interface
- `CNT_W`, 32: width of every counter and of `rd_data`.
- `clk`  input  1  core clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `PC`  input  32  fetch-stage program counter from MISP.
- `Instr`  input  32  instruction fetched at `PC`, same cycle.
- `count_en`  input  1  counting enabled this cycle; when 0, no state changes except snapshot/clear/read.
- `clear`  input  1  synchronous clear of live counters and history.
- `snap`  input  1  single-cycle pulse: copy all live counters into shadow registers.
- `rd_sel`  input  3  shadow counter select for the read port.
- `rd_data`  output  CNT_W  selected shadow counter, registered.
- `misalign_err`  output  1  sticky flag, set on any sampled PC with `PC[1:0] != 0`.

## Operation
- A cycle is sampled when `count_en=1`, `clear=0`, and reset is deasserted.
- History: `pc_q` (32b) and `hist_v` (1b) hold the PC of the previous sampled cycle. Both update on every sampled cycle.
- Classification of a sampled cycle:
  - `fetch` is true when `!hist_v` or `PC != pc_q`.
  - `stall` is true when `hist_v` and `PC == pc_q`.
  - `redirect` is true when `hist_v`, `PC != pc_q`, and `PC != pc_q + 4`. The add is 32-bit modulo, so `0xFFFFFFFC -> 0x00000000` is sequential, not a redirect.
  - On a `fetch` cycle, opcode `Instr[31:26]` is classified as load (`6'h23`), store (`6'h2B`), or branch (`6'h04`/`6'h05`). Stalled cycles never reclassify.
  - `misalign` is true when `PC[1:0] != 0`; it is counted on every sampled cycle, fetch or stall.
- Live counters and `rd_sel` encoding:
  - 0 = cycles (every sampled cycle)
  - 1 = fetches
  - 2 = stalls
  - 3 = redirects
  - 4 = loads
  - 5 = stores
  - 6 = branches
  - 7 = misaligned
- Each counter saturates at `2^CNT_W - 1` and never wraps.
- `clear`:
  - zeroes all live counters and `hist_v`; `pc_q` becomes don't-care;
  - does not touch shadow registers or `misalign_err`;
  - the cycle carrying `clear` is not sampled.
- `snap`: shadow registers get the live values as they stand before that edge's update, i.e. the same-cycle event is excluded.
- `snap` and `clear` in the same cycle: shadow captures the pre-clear values, then the live counters clear.
- `misalign_err` sets on the edge after the first misaligned sample. Only reset clears it.
- `rd_data` is registered from `shadow[rd_sel]`. A `rd_sel` change is visible on the next edge.
- Reset (asynchronous, any time, including mid-operation):
  - all live and shadow counters, `pc_q`, `hist_v`, `rd_data`, and `misalign_err` go to 0;
  - deassertion takes effect at the next rising edge.

## Timing
- Counter update latency is one edge. An event sampled in cycle N appears in the live counter after edge N.
- Snapshot-to-read latency: `snap` at edge N loads the shadow; with `rd_sel` stable, `rd_data` reflects it after edge N+1.
- Read latency: one cycle from `rd_sel` to `rd_data`.
- No handshake back-pressure exists. `snap` may be asserted every cycle; each assertion overwrites the shadow.
- `count_en=0` freezes `pc_q` and `hist_v`. On resumption, the first PC is compared against the last sampled PC, not against the PCs seen while frozen.
- Critical path: the 32-bit `pc_q + 4` compare plus counter increment. This must close at the core clock.

## Test plan
- Sequential fetch:
  - Stimulus: after reset, `count_en=1`, `PC` = `0x0, 0x4, 0x8, 0xC` with `Instr` opcodes `0x23, 0x2B, 0x04, 0x00`, then `snap`.
  - Required response: cycles=4, fetches=4, stalls=0, redirects=0, loads=1, stores=1, branches=1.
- Stall and redirect:
  - Stimulus: `PC` = `0x10, 0x10, 0x10, 0x40, 0x44`, with a load opcode held during the stall.
  - Required response: stalls=2, fetches=3, redirects=1, loads=1 (not 3).
- Wrap-around:
  - Stimulus: `PC` = `0xFFFFFFFC, 0x00000000`.
  - Required response: redirects=0, fetches=2.
- Misalignment:
  - Stimulus: `PC` = `0x0, 0x6, 0x6`.
  - Required response: misaligned=2, `misalign_err=1` after the second edge; it stays set after `clear`.
- Snap with clear:
  - Stimulus: accumulate cycles=5, then assert `snap` and `clear` together, then sample `0x100` with `rd_sel=0`.
  - Required response: `rd_data`=5. A second `snap` then yields cycles=1, fetches=1, redirects=0.
- Reset and saturation:
  - Stimulus: assert reset mid-run.
  - Required response: `rd_data` and all counters read 0 immediately.
  - Stimulus: build with `CNT_W=4` and run 20 sampled cycles.
  - Required response: cycles=15.
